// File: rtl/regfile_pkg.sv
// regfile_pkg: shared clear-FSM state enum, default widths and the zero-register index for regfile_mp
package regfile_pkg;
  typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_D_WIDTH = 32;
  localparam int ZERO_REG = 0;
endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: one registered read port (clk, rst_n, clr, addr, arr_data, we/wa/wd x2 -> rd_data), zero-reg masked, same-cycle write bypass under REGFILE_BYPASS_EN
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int D_WIDTH = RF_D_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [D_WIDTH-1:0]    arr_data,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] wa0,
  input  logic [ADDR_WIDTH-1:0] wa1,
  input  logic [D_WIDTH-1:0]    wd0,
  input  logic [D_WIDTH-1:0]    wd1,
  output logic [D_WIDTH-1:0]    rd_data
);
  logic [D_WIDTH-1:0] fwd;
`ifdef REGFILE_BYPASS_EN
  always_comb fwd = (we1 && wa1 == addr) ? wd1 : (we0 && wa0 == addr) ? wd0 : arr_data;
`else
  logic unused_byp;
  assign unused_byp = ^{we0, we1, wa0, wa1, wd0, wd1};
  always_comb fwd = arr_data;
`endif
  always_ff @(posedge clk)
    rd_data <= (!rst_n || clr || addr == ADDR_WIDTH'(ZERO_REG)) ? '0 : fwd;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file (clk, rst_n, clear_req, busy, rd_addr/rd_data x NUM_RD, we/wa/wd x2) with hw clear sequencer, optional bypass via REGFILE_BYPASS_EN
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int D_WIDTH = RF_D_WIDTH,
  parameter int NUM_RD = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear_req,
  output logic                         busy,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*D_WIDTH-1:0]    rd_data,
  input  logic                         we0,
  input  logic                         we1,
  input  logic [ADDR_WIDTH-1:0]        wa0,
  input  logic [ADDR_WIDTH-1:0]        wa1,
  input  logic [D_WIDTH-1:0]           wd0,
  input  logic [D_WIDTH-1:0]           wd1
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  rf_state_t state, state_n;
  logic [ADDR_WIDTH-1:0] clr_idx, clr_idx_n;
  logic [D_WIDTH-1:0] mem [DEPTH];
  assign busy = state == RF_CLEAR;
  always_comb begin
    state_n = state;
    clr_idx_n = clr_idx;
    if (state == RF_CLEAR) begin
      state_n = &clr_idx ? RF_IDLE : RF_CLEAR;
      clr_idx_n = &clr_idx ? clr_idx : clr_idx + 1'b1;
    end else if (clear_req) begin
      state_n = RF_CLEAR;
      clr_idx_n = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RF_CLEAR;
      clr_idx <= '0;
    end else begin
      state <= state_n;
      clr_idx <= clr_idx_n;
    end
  end
  always_ff @(posedge clk) begin
    if (state == RF_CLEAR) mem[clr_idx] <= '0;
    else if (rst_n) begin
      if (we0 && wa0 != ADDR_WIDTH'(ZERO_REG)) mem[wa0] <= wd0;
      if (we1 && wa1 != ADDR_WIDTH'(ZERO_REG)) mem[wa1] <= wd1;
    end
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_rdport #(.ADDR_WIDTH(ADDR_WIDTH), .D_WIDTH(D_WIDTH)) u_rd (
      .clk(clk),
      .rst_n(rst_n),
      .clr(busy),
      .addr(rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .arr_data(mem[rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]]),
      .we0(we0),
      .we1(we1),
      .wa0(wa0),
      .wa1(wa1),
      .wd0(wd0),
      .wd1(wd1),
      .rd_data(rd_data[k*D_WIDTH +: D_WIDTH])
    );
  end
endmodule
